uart_rx: RTL

Serial receiver that is the downstream counterpart of the UART transmitter. It takes an asynchronous 8N1 line (1 start bit, 8 data bits LSB first, 1 stop bit; idle high), samples each bit at its centre, and presents each received byte on a held output register with a ready/read handshake. It also flags framing errors and overrun. In the CPU system it sits between the board RX pin and the I/O register bank, and can be looped back to `uart_tx` for self-test.

---
 rtl/uart_rx.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver with centre sampling and a held output byte
//
// Receives 1 start bit, 8 data bits (LSB first) and 1 stop bit on an idle-high
// asynchronous line. Each good byte is loaded into a held output register and
// flagged with a ready level that the consumer clears with a read strobe.
//
// Parameters:
//   CLK_PER_BIT  clock cycles per bit, legal range 8..65535 (default 434)
//
// Ports:
//   clk         single clock, all flops on the rising edge
//   rst         synchronous active-high reset
//   rx          asynchronous serial input, idle high
//   rd          read strobe, clears data_ready and overrun
//   data_out    last good byte received, held until the next good byte
//   data_ready  high while an unread byte sits in data_out
//   overrun     sticky: a good byte completed while an unread byte was pending
//   frame_err   one-cycle pulse when the stop bit is sampled low
//   busy        high while a frame is being received (START/DATA/STOP)
//
// Optional feature (macro UART_RX_MAJORITY_EN):
//   When defined, every bit decision is the 2-of-3 majority of the
//   synchronised line over the decision edge and the two edges before it,
//   which rejects a single-cycle glitch at sample time. Latency is unchanged.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int unsigned CLK_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] MID  = 16'((CLK_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLK_PER_BIT - 1);

  localparam logic [2:0] ST_BREAK = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  logic        rxMeta_q;
  logic        rxSync_q;
  logic [1:0]  syncPrimed_q;
  logic [2:0]  state_q,     state_d;
  logic [15:0] clkCount_q,  clkCount_d;
  logic [2:0]  bitIndex_q,  bitIndex_d;
  logic [7:0]  shift_q,     shift_d;
  logic [7:0]  dataOut_q,   dataOut_d;
  logic        dataReady_q, dataReady_d;
  logic        overrun_q,   overrun_d;
  logic        frameErr_q,  frameErr_d;
  logic        byteDone;
  logic        decision;

  // Two-flop synchroniser. Both stages reset high so the line looks idle.
  // syncPrimed_q fills with ones over the two cycles after reset; until then
  // rxSync_q still carries its reset value rather than the real line, and
  // BREAK must not treat that as the line having returned high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta_q     <= 1'b1;
      rxSync_q     <= 1'b1;
      syncPrimed_q <= 2'b00;
    end else begin
      rxMeta_q     <= rx;
      rxSync_q     <= rxMeta_q;
      syncPrimed_q <= {syncPrimed_q[0], 1'b1};
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // History of the two previous synchronised samples for the majority vote.
  logic [1:0] rxHist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxHist_q <= 2'b11;
    end else begin
      rxHist_q <= {rxHist_q[0], rxSync_q};
    end
  end

  assign decision = (rxSync_q & rxHist_q[0]) |
                    (rxSync_q & rxHist_q[1]) |
                    (rxHist_q[0] & rxHist_q[1]);
`else
  assign decision = rxSync_q;
`endif

  // Receive FSM plus the output handshake. A completed good byte always
  // overwrites data_out; a simultaneous read lets the new byte win without
  // raising overrun.
  always_comb begin
    state_d     = state_q;
    clkCount_d  = clkCount_q;
    bitIndex_d  = bitIndex_q;
    shift_d     = shift_q;
    dataOut_d   = dataOut_q;
    dataReady_d = dataReady_q;
    overrun_d   = overrun_q;
    frameErr_d  = 1'b0;
    byteDone    = 1'b0;

    case (state_q)
      ST_BREAK: begin
        if (syncPrimed_q[1] && rxSync_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!rxSync_q) begin
          clkCount_d = 16'd0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (clkCount_q == MID) begin
          if (decision) begin
            state_d = ST_IDLE;
          end else begin
            clkCount_d = 16'd0;
            bitIndex_d = 3'd0;
            state_d    = ST_DATA;
          end
        end else begin
          clkCount_d = clkCount_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (clkCount_q == LAST) begin
          shift_d    = {decision, shift_q[7:1]};
          clkCount_d = 16'd0;
          bitIndex_d = bitIndex_q + 3'd1;
          if (bitIndex_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          clkCount_d = clkCount_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (clkCount_q == LAST) begin
          if (decision) begin
            byteDone = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            frameErr_d = 1'b1;
            state_d    = ST_BREAK;
          end
        end else begin
          clkCount_d = clkCount_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_BREAK;
      end
    endcase

    if (byteDone) begin
      dataOut_d   = shift_q;
      dataReady_d = 1'b1;
      if (rd) begin
        overrun_d = 1'b0;
      end else if (dataReady_q) begin
        overrun_d = 1'b1;
      end
    end else if (rd && dataReady_q) begin
      dataReady_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BREAK;
      clkCount_q  <= 16'd0;
      bitIndex_q  <= 3'd0;
      shift_q     <= 8'h00;
      dataOut_q   <= 8'h00;
      dataReady_q <= 1'b0;
      overrun_q   <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clkCount_q  <= clkCount_d;
      bitIndex_q  <= bitIndex_d;
      shift_q     <= shift_d;
      dataOut_q   <= dataOut_d;
      dataReady_q <= dataReady_d;
      overrun_q   <= overrun_d;
      frameErr_q  <= frameErr_d;
    end
  end

  assign data_out   = dataOut_q;
  assign data_ready = dataReady_q;
  assign overrun    = overrun_q;
  assign frame_err  = frameErr_q;
  assign busy       = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_STOP);

endmodule
